hit_envelope_gen: RTL and testbench

- Upstream stage of the PWM serializer.
- Converts raw 2-bit hit events from game logic into a time-varying duty cycle (0..99) with an attack/hold/decay envelope.
- Drives the serializer's duty_cycle and hit inputs, so a hit produces a PWM burst that swells and fades rather than a hard on/off.

---
 rtl/hit_envelope_gen.sv | 134 +++++++++++++
 tb/tb_hit_envelope_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hit_envelope_gen.sv
// Hit-to-duty envelope generator (attack/hold/decay) ahead of the PWM serializer.
// Optional: define HIT_ENV_EXP_DECAY_EN for duty>>3 (min 1) decay steps.
module hit_envelope_gen #(
  parameter int TICK_DIV    = 100000,
  parameter int SOFT_DUTY   = 50,
  parameter int HARD_DUTY   = 99,
  parameter int ATTACK_STEP = 10,
  parameter int DECAY_STEP  = 1,
  parameter int HOLD_TICKS  = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] hit_in,
  output logic [6:0] duty_cycle,
  output logic [1:0] hit_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    HOLD,
    DECAY
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [PW-1:0] PS_LAST   = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [6:0]    SOFT_T    = 7'(SOFT_DUTY);
  localparam logic [6:0]    HARD_T    = 7'(HARD_DUTY);
  localparam logic [8:0]    ATK       = 9'(ATTACK_STEP);

  state_t          state;
  logic [PW-1:0]   presc;
  logic [HW-1:0]   hold_cnt;
  logic [1:0]      hit_q;
  logic            armed;
  logic [6:0]      target;

  logic            ev;
  logic            accept;
  logic            tick;
  logic [6:0]      ev_tgt;
  logic [8:0]      atk_sum;
  logic [6:0]      dec_step;
  logic [6:0]      dec_next;

  function automatic logic [1:0] strength(input logic [1:0] h);
    logic [1:0] s;
    s = 2'd0;
    unique case (1'b1)
      h[1]:          s = 2'd2;
      (h == 2'b01):  s = 2'd1;
      default:       s = 2'd0;
    endcase
    return s;
  endfunction

  // the level present at reset release is history, not a fresh hit
  assign ev = armed && (hit_in != 2'b00) &&
              ((hit_q == 2'b00) ||
               (strength(hit_in) > strength(hit_q)));

  assign ev_tgt  = hit_in[1] ? HARD_T : SOFT_T;
  assign accept  = ev && (ev_tgt >= duty_cycle);
  assign tick    = (state != IDLE) && (presc == PS_LAST);
  assign atk_sum = {2'b00, duty_cycle} + ATK;

`ifdef HIT_ENV_EXP_DECAY_EN
  assign dec_step = (duty_cycle[6:3] != 4'd0) ?
                    {3'b000, duty_cycle[6:3]} : 7'd1;
`else
  assign dec_step = 7'(DECAY_STEP);
`endif

  assign dec_next = (duty_cycle > dec_step) ?
                    (duty_cycle - dec_step) : 7'd0;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      presc      <= '0;
      hold_cnt   <= '0;
      hit_q      <= 2'b00;
      armed      <= 1'b0;
      target     <= 7'd0;
      duty_cycle <= 7'd0;
      hit_out    <= 2'b00;
    end else begin
      hit_q <= hit_in;
      armed <= 1'b1;
      if (accept) begin
        state   <= ATTACK;
        presc   <= '0;
        hit_out <= hit_in;
        target  <= ev_tgt;
      end else if (state == IDLE) begin
        presc <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          case (state)
            ATTACK: begin
              if (atk_sum >= {2'b00, target}) begin
                duty_cycle <= target;
                state      <= HOLD;
                hold_cnt   <= '0;
              end else begin
                duty_cycle <= atk_sum[6:0];
              end
            end
            HOLD: begin
              if (hold_cnt == HOLD_LAST) state <= DECAY;
              else hold_cnt <= hold_cnt + 1'b1;
            end
            DECAY: begin
              duty_cycle <= dec_next;
              if (dec_next == 7'd0) begin
                state   <= IDLE;
                hit_out <= 2'b00;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_hit_envelope_gen.sv
// Directed bench for hit_envelope_gen with a cycle model and literal checkpoints.
// Build with HIT_ENV_EXP_DECAY_EN to exercise the exponential fade.
module tb_hit_envelope_gen;

  localparam int TD = 4;
  localparam int HT = 2;

  logic       clk;
  logic       reset_n;
  logic [1:0] hit_in;
  logic [6:0] duty_cycle;
  logic [1:0] hit_out;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  hit_envelope_gen #(
    .TICK_DIV   (TD),
    .SOFT_DUTY  (50),
    .HARD_DUTY  (99),
    .ATTACK_STEP(10),
    .DECAY_STEP (1),
    .HOLD_TICKS (HT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .hit_in    (hit_in),
    .duty_cycle(duty_cycle),
    .hit_out   (hit_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: phase 0 idle, 1 rise, 2 peak, 3 fade
  int m_duty, m_hit, m_tgt, m_phase;
  int m_cyc, m_hold, m_prev, m_armed;
  int s_new, tgt, stp;

  function automatic int str(input int h);
    return (h == 0) ? 0 : ((h == 1) ? 1 : 2);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_duty = 0; m_hit = 0; m_tgt = 0; m_phase = 0;
      m_cyc = 0; m_hold = 0; m_prev = 0; m_armed = 0;
    end else begin
      s_new = str(int'(hit_in));
      tgt = (s_new == 2) ? 99 : 50;
      if (m_armed == 1 && s_new > str(m_prev) && tgt >= m_duty) begin
        m_phase = 1; m_cyc = 0;
        m_hit = int'(hit_in); m_tgt = tgt;
      end else if (m_phase != 0) begin
        m_cyc++;
        if (m_cyc == TD) begin
          m_cyc = 0;
          if (m_phase == 1) begin
            m_duty = (m_duty + 10 > m_tgt) ? m_tgt : m_duty + 10;
            if (m_duty == m_tgt) begin m_phase = 2; m_hold = 0; end
          end else if (m_phase == 2) begin
            m_hold++;
            if (m_hold == HT) m_phase = 3;
          end else begin
`ifdef HIT_ENV_EXP_DECAY_EN
            stp = (m_duty / 8 > 1) ? m_duty / 8 : 1;
`else
            stp = 1;
`endif
            m_duty = (m_duty > stp) ? m_duty - stp : 0;
            if (m_duty == 0) begin m_phase = 0; m_hit = 0; end
          end
        end
      end
      m_prev = int'(hit_in);
      m_armed = 1;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      vectors++;
      if (duty_cycle !== 7'(m_duty) || hit_out !== 2'(m_hit) ||
          busy !== (m_phase != 0)) begin
        errors++;
        $display("FAIL model t=%0t duty %0d want %0d hit %0d want %0d busy %0d want %0d",
                 $time, duty_cycle, m_duty, hit_out, m_hit, busy, m_phase != 0);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      cyc(1);
      n++;
    end
    chk(name, int'(busy), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    hit_in  = 2'b10;
    cyc(3);
    chk("rst_duty", duty_cycle, 0);
    chk("rst_hit", hit_out, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    cyc(4);
    chk("rel_busy", busy, 0);
    chk("rel_duty", duty_cycle, 0);
    hit_in = 2'b00;
    cyc(2);

    // soft burst
    hit_in = 2'b01;
    cyc(1);
    chk("soft_busy", busy, 1);
    chk("soft_hit", hit_out, 1);
    chk("soft_d0", duty_cycle, 0);
    cyc(3);
    chk("soft_pretick", duty_cycle, 0);
    cyc(1);
    chk("soft_d10", duty_cycle, 10);
    cyc(16);
    chk("soft_peak", duty_cycle, 50);
    cyc(8);
    chk("soft_holdend", duty_cycle, 50);
    cyc(4);
`ifdef HIT_ENV_EXP_DECAY_EN
    chk("soft_dec1", duty_cycle, 44);
    wait_idle("soft_idle_to", 1000);
`else
    chk("soft_dec1", duty_cycle, 49);
    cyc(192);
    chk("soft_last1", duty_cycle, 1);
    chk("soft_last_busy", busy, 1);
    cyc(4);
    chk("soft_end_busy", busy, 0);
`endif
    chk("soft_end_duty", duty_cycle, 0);
    chk("soft_end_hit", hit_out, 0);

    // upgrade to hard during hold
    hit_in = 2'b00;
    cyc(2);
    hit_in = 2'b01;
    cyc(1);
    cyc(20);
    chk("up_soft_peak", duty_cycle, 50);
    cyc(1);
    hit_in = 2'b10;
    cyc(1);
    chk("up_hit", hit_out, 2);
    chk("up_d50", duty_cycle, 50);
    cyc(4);
    chk("up_d60", duty_cycle, 60);
    cyc(12);
    chk("up_d90", duty_cycle, 90);
    cyc(4);
    chk("up_sat99", duty_cycle, 99);

    // soft during hard burst is ignored
    hit_in = 2'b00;
    cyc(1);
    hit_in = 2'b01;
    cyc(2);
    chk("dn_duty", duty_cycle, 99);
    chk("dn_hit", hit_out, 2);
    chk("dn_busy", busy, 1);
    cyc(9);
`ifdef HIT_ENV_EXP_DECAY_EN
    chk("hard_dec1", duty_cycle, 87);
    cyc(8);
    chk("hard_dec3", duty_cycle, 68);
`else
    chk("hard_dec1", duty_cycle, 98);
    cyc(8);
    chk("hard_dec3", duty_cycle, 96);
`endif
    wait_idle("hard_idle_to", 1000);
    chk("hard_end_hit", hit_out, 0);
    cyc(5);
    chk("no_repeat", busy, 0);

    // async reset mid-attack
    hit_in = 2'b00;
    cyc(2);
    hit_in = 2'b10;
    cyc(1);
    cyc(12);
    chk("ar_d30", duty_cycle, 30);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_duty", duty_cycle, 0);
    chk("ar_busy", busy, 0);
    chk("ar_hit", hit_out, 0);
    hit_in = 2'b00;
    cyc(1);
    reset_n = 1'b1;
    cyc(3);
    chk("ar_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
